imem_loader: RTL and testbench

- Byte-stream bootloader: the write side of the 512x16 instruction memory, which itself is combinational read only.
- Receives a framed program image over a valid/ready byte interface and assembles 16-bit words.
- Issues one-cycle write strobes to the instruction memory write port.
- Holds the CPU stalled while loading and reports done/error status.

---
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream bootloader: parses framed program images and drives the
// instruction memory write port, holding the CPU while a frame is in flight.
module imem_loader #(
    parameter int unsigned MEM_DEPTH = 512,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int unsigned AW = 16;
    localparam int unsigned BW = 8;

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   chk_q, chk_d;
    logic [BW-1:0]   hi_q, hi_d;
    logic            we_d, hold_d, done_d, err_d;
    logic [AW-1:0]   maddr_d, wdata_d;
    logic            accept;
    logic [AW-1:0]   cnt_new;
    logic [AW:0]     range_end;

    // A write cycle blocks acceptance so at most one byte lands per write.
    assign in_ready  = ~mem_we;
    assign accept    = in_valid & in_ready;
    assign busy      = cpu_hold;
    assign cnt_new   = {cnt_q[AW-1:BW], in_data};
    assign range_end = (AW+1)'(addr_q) + (AW+1)'(cnt_new);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        maddr_d = mem_addr;
        wdata_d = mem_wdata;
        done_d  = 1'b0;
        err_d   = error;
        if (accept) begin
            if (state_q != IDLE && state_q != CHECK) chk_d = chk_q ^ in_data;
            case (state_q)
                IDLE: begin
                    if (in_data == SYNC_BYTE) begin
                        state_d = ADDR_HI;
                        err_d   = 1'b0;
                        chk_d   = '0;
                    end
                end
                ADDR_HI: begin
                    addr_d[AW-1:BW] = in_data;
                    state_d         = ADDR_LO;
                end
                ADDR_LO: begin
                    addr_d[BW-1:0] = in_data;
                    state_d        = CNT_HI;
                end
                CNT_HI: begin
                    cnt_d[AW-1:BW] = in_data;
                    state_d        = CNT_LO;
                end
                CNT_LO: begin
                    cnt_d = cnt_new;
                    if (range_end > (AW+1)'(MEM_DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (cnt_new == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
                DATA_HI: begin
                    hi_d    = in_data;
                    state_d = DATA_LO;
                end
                DATA_LO: begin
                    // Strobe next cycle with the pre-increment address.
                    we_d    = 1'b1;
                    maddr_d = addr_q;
                    wdata_d = {hi_q, in_data};
                    addr_d  = addr_q + AW'(1);
                    cnt_d   = cnt_q - AW'(1);
                    state_d = (cnt_q == AW'(1)) ? CHECK : DATA_HI;
                end
                CHECK: begin
                    if (chk_q == in_data) done_d = 1'b1;
                    else                  err_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        hold_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            chk_q     <= '0;
            hi_q      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            chk_q     <= chk_d;
            hi_q      <= hi_d;
            mem_we    <= we_d;
            mem_addr  <= maddr_d;
            mem_wdata <= wdata_d;
            cpu_hold  <= hold_d;
            done      <= done_d;
            error     <= err_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Table-driven bench for imem_loader: per-cycle stimulus rows with
// hand-computed expected outputs, plus an asynchronous reset sequence.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, cpu_hold, busy, done, error;
    logic [15:0] mem_addr, mem_wdata;

    imem_loader dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic        we;
        logic [15:0] a;
        logic [15:0] w;
        logic        hold;
        logic        done;
        logic        err;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] ta = 16'h0000;
    logic [15:0] tw = 16'h0000;
    int          applied = 0;
    int          miscompares = 0;

    // Address/data expectations persist between writes, as the outputs do.
    task automatic r(input logic [7:0] d, input logic v, we, hold, dn, err,
                     input logic [15:0] a = 16'h0, input logic [15:0] w = 16'h0);
        vec_t x;
        if (we) begin
            ta = a;
            tw = w;
        end
        x.d = d; x.v = v; x.we = we; x.a = ta; x.w = tw;
        x.hold = hold; x.done = dn; x.err = err;
        tbl.push_back(x);
    endtask

    task automatic check(input string name, input logic we, input logic [15:0] a,
                         input logic [15:0] w, input logic hold, dn, err);
        applied++;
        if (mem_we !== we || mem_addr !== a || mem_wdata !== w || in_ready !== ~we ||
            cpu_hold !== hold || busy !== hold || done !== dn || error !== err) begin
            miscompares++;
            $display("FAIL %s: got we=%b addr=%h wdata=%h ready=%b hold=%b busy=%b done=%b err=%b; want we=%b addr=%h wdata=%h ready=%b hold=%b done=%b err=%b",
                     name, mem_we, mem_addr, mem_wdata, in_ready, cpu_hold, busy, done, error,
                     we, a, w, ~we, hold, dn, err);
        end
    endtask

    task automatic run(input string tag);
        foreach (tbl[i]) begin
            @(negedge clk);
            in_data  = tbl[i].d;
            in_valid = tbl[i].v;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i), tbl[i].we, tbl[i].a, tbl[i].w,
                  tbl[i].hold, tbl[i].done, tbl[i].err);
        end
        tbl.delete();
    endtask

    // 0x0010 <- 1234, 0x0011 <- ABCD; good checksum is 0x52.
    task automatic basic_frame(input logic [7:0] chk, input logic bad);
        r(8'hA5,1,0,1,0,0); r(8'h00,1,0,1,0,0); r(8'h10,1,0,1,0,0);
        r(8'h00,1,0,1,0,0); r(8'h02,1,0,1,0,0); r(8'h12,1,0,1,0,0);
        r(8'h34,1,1,1,0,0,16'h0010,16'h1234);
        r(8'hAB,1,0,1,0,0); r(8'hAB,1,0,1,0,0);
        r(8'hCD,1,1,1,0,0,16'h0011,16'hABCD);
        r(chk,1,0,1,0,0);
        r(chk,1,0,0,!bad,bad);
        r(8'h00,0,0,0,0,bad);
    endtask

    initial begin
        #12;
        check("reset_state", 0, 16'h0, 16'h0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        basic_frame(8'h52, 1'b0);
        run("basic");

        basic_frame(8'h53, 1'b1);
        r(8'h12,1,0,0,0,1);
        run("badchk");

        // 0x1FF + 2 overruns the memory; trailing bytes must be dropped.
        r(8'hA5,1,0,1,0,0); r(8'h01,1,0,1,0,0); r(8'hFF,1,0,1,0,0);
        r(8'h00,1,0,1,0,0); r(8'h02,1,0,0,0,1);
        r(8'h11,1,0,0,0,1); r(8'h22,1,0,0,0,1); r(8'h33,1,0,0,0,1);
        run("range");

        // 0x1FE + 2 ends exactly at the top of memory and is legal.
        r(8'hA5,1,0,1,0,0); r(8'h01,1,0,1,0,0); r(8'hFE,1,0,1,0,0);
        r(8'h00,1,0,1,0,0); r(8'h02,1,0,1,0,0); r(8'h55,1,0,1,0,0);
        r(8'h55,1,1,1,0,0,16'h01FE,16'h5555);
        r(8'hAA,1,0,1,0,0); r(8'hAA,1,0,1,0,0);
        r(8'hAA,1,1,1,0,0,16'h01FF,16'hAAAA);
        r(8'hFD,1,0,1,0,0); r(8'hFD,1,0,0,1,0); r(8'h00,0,0,0,0,0);
        run("boundary");

        r(8'hA5,1,0,1,0,0); r(8'h00,1,0,1,0,0); r(8'h00,1,0,1,0,0);
        r(8'h00,1,0,1,0,0); r(8'h00,1,0,1,0,0);
        r(8'h00,1,0,0,1,0); r(8'h00,0,0,0,0,0);
        run("zerocnt");

        // Gaps in in_valid, and a sync-valued data word treated as data.
        r(8'hA5,1,0,1,0,0); r(8'h00,0,0,1,0,0); r(8'h00,1,0,1,0,0);
        r(8'h20,1,0,1,0,0); r(8'h00,0,0,1,0,0); r(8'h00,0,0,1,0,0);
        r(8'h00,1,0,1,0,0); r(8'h01,1,0,1,0,0); r(8'hA5,1,0,1,0,0);
        r(8'h00,0,0,1,0,0); r(8'hA5,1,1,1,0,0,16'h0020,16'hA5A5);
        r(8'h21,0,0,1,0,0); r(8'h21,1,0,0,1,0); r(8'h00,0,0,0,0,0);
        run("gaps");

        // Async reset while the first write strobe is high.
        r(8'hA5,1,0,1,0,0); r(8'h00,1,0,1,0,0); r(8'h10,1,0,1,0,0);
        r(8'h00,1,0,1,0,0); r(8'h02,1,0,1,0,0); r(8'h12,1,0,1,0,0);
        r(8'h34,1,1,1,0,0,16'h0010,16'h1234);
        run("prereset");
        #2;
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("async_reset", 0, 16'h0, 16'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("reset_held", 0, 16'h0, 16'h0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        ta = 16'h0000;
        tw = 16'h0000;

        r(8'hAB,1,0,0,0,0); r(8'hCD,1,0,0,0,0);
        r(8'h00,1,0,0,0,0); r(8'hFF,1,0,0,0,0);
        r(8'hA5,1,0,1,0,0); r(8'h00,1,0,1,0,0); r(8'h30,1,0,1,0,0);
        r(8'h00,1,0,1,0,0); r(8'h01,1,0,1,0,0); r(8'hBE,1,0,1,0,0);
        r(8'hEF,1,1,1,0,0,16'h0030,16'hBEEF);
        r(8'h60,1,0,1,0,0); r(8'h60,1,0,0,1,0); r(8'h00,0,0,0,0,0);
        run("postreset");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
